// File: rtl/lab3_mem_blocking_cache_base_ctrl.sv
// rtl/lab3_mem_blocking_cache_base_ctrl.sv - control FSM for the 256B direct-mapped write-back blocking cache
module lab3_mem_blocking_cache_base_ctrl #(
    parameter int unsigned p_idx_shamt = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cachereq_val_i,
    output logic        cachereq_rdy_o,
    output logic        cacheresp_val_o,
    input  logic        cacheresp_rdy_i,
    output logic        memreq_val_o,
    input  logic        memreq_rdy_i,
    input  logic        memresp_val_i,
    output logic        memresp_rdy_o,
    input  logic [2:0]  cachereq_type_i,
    input  logic [31:0] cachereq_addr_i,
    input  logic        tag_match_i,
    output logic        cachereq_en_o,
    output logic        tag_array_ren_o,
    output logic        tag_array_wen_o,
    output logic        data_array_ren_o,
    output logic        data_array_wen_o,
    output logic [15:0] data_array_wben_o,
    output logic        write_data_mux_sel_o,
    output logic        read_data_reg_en_o,
    output logic [2:0]  read_word_mux_sel_o,
    output logic        hit_reg_en_o,
    output logic [1:0]  tag_check_hit_o,
    output logic [2:0]  cacheresp_type_o,
    output logic        memreq_addr_mux_sel_o,
    output logic [2:0]  memreq_type_o,
    output logic        memresp_data_reg_en_o,
    output logic        evict_addr_reg_en_o
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_TAG_CHECK, ST_INIT_DATA, ST_READ_DATA, ST_WRITE_DATA,
        ST_EVICT_PREP, ST_EVICT_REQ, ST_EVICT_WAIT, ST_REFILL_REQ,
        ST_REFILL_WAIT, ST_REFILL_UPDATE, ST_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] valid_q, dirty_q;

    logic [3:0]  idx;
    logic [1:0]  off;
    logic        is_write, is_init, hit;
    logic [15:0] word_wben;
    logic        unused_addr;

    assign idx         = cachereq_addr_i[7+p_idx_shamt -: 4];
    assign off         = cachereq_addr_i[3:2];
    assign unused_addr = ^cachereq_addr_i;
    // Any type other than write or init behaves as a read.
    assign is_write    = (cachereq_type_i == 3'd1);
    assign is_init     = (cachereq_type_i == 3'd2);
    assign hit         = valid_q[idx] & tag_match_i & ~is_init;
    assign word_wben   = 16'h000F << {off, 2'b00};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_INIT_DATA, ST_REFILL_UPDATE: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                end
                ST_WRITE_DATA: dirty_q[idx] <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:          if (cachereq_val_i) state_d = ST_TAG_CHECK;
            ST_TAG_CHECK: begin
                if (is_init)                              state_d = ST_INIT_DATA;
                else if (hit)                             state_d = is_write ? ST_WRITE_DATA : ST_READ_DATA;
                else if (valid_q[idx] && dirty_q[idx])    state_d = ST_EVICT_PREP;
                else                                      state_d = ST_REFILL_REQ;
            end
            ST_INIT_DATA,
            ST_READ_DATA,
            ST_WRITE_DATA:    state_d = ST_WAIT;
            ST_EVICT_PREP:    state_d = ST_EVICT_REQ;
            ST_EVICT_REQ:     if (memreq_rdy_i)    state_d = ST_EVICT_WAIT;
            ST_EVICT_WAIT:    if (memresp_val_i)   state_d = ST_REFILL_REQ;
            ST_REFILL_REQ:    if (memreq_rdy_i)    state_d = ST_REFILL_WAIT;
            ST_REFILL_WAIT:   if (memresp_val_i)   state_d = ST_REFILL_UPDATE;
            ST_REFILL_UPDATE: state_d = is_write ? ST_WRITE_DATA : ST_READ_DATA;
            ST_WAIT:          if (cacheresp_rdy_i) state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, including the IDLE ready.
    always_comb begin
        cachereq_rdy_o        = 1'b0;
        cacheresp_val_o       = 1'b0;
        memreq_val_o          = 1'b0;
        memresp_rdy_o         = 1'b0;
        cachereq_en_o         = 1'b0;
        tag_array_ren_o       = 1'b0;
        tag_array_wen_o       = 1'b0;
        data_array_ren_o      = 1'b0;
        data_array_wen_o      = 1'b0;
        data_array_wben_o     = 16'h0000;
        write_data_mux_sel_o  = 1'b0;
        read_data_reg_en_o    = 1'b0;
        read_word_mux_sel_o   = 3'd0;
        hit_reg_en_o          = 1'b0;
        tag_check_hit_o       = 2'd0;
        cacheresp_type_o      = 3'd0;
        memreq_addr_mux_sel_o = 1'b0;
        memreq_type_o         = 3'd0;
        memresp_data_reg_en_o = 1'b0;
        evict_addr_reg_en_o   = 1'b0;
        if (rst_ni) begin
            case (state_q)
                ST_IDLE: begin
                    cachereq_rdy_o = 1'b1;
                    cachereq_en_o  = cachereq_val_i;
                end
                ST_TAG_CHECK: begin
                    tag_array_ren_o = 1'b1;
                    hit_reg_en_o    = 1'b1;
                    tag_check_hit_o = {1'b0, hit};
                end
                ST_INIT_DATA: begin
                    tag_array_wen_o      = 1'b1;
                    data_array_wen_o     = 1'b1;
                    write_data_mux_sel_o = 1'b1;
                    data_array_wben_o    = word_wben;
                end
                ST_READ_DATA: begin
                    data_array_ren_o   = 1'b1;
                    read_data_reg_en_o = 1'b1;
                end
                ST_WRITE_DATA: begin
                    data_array_wen_o     = 1'b1;
                    write_data_mux_sel_o = 1'b1;
                    data_array_wben_o    = word_wben;
                end
                ST_EVICT_PREP: begin
                    tag_array_ren_o     = 1'b1;
                    data_array_ren_o    = 1'b1;
                    read_data_reg_en_o  = 1'b1;
                    evict_addr_reg_en_o = 1'b1;
                end
                ST_EVICT_REQ: begin
                    memreq_val_o          = 1'b1;
                    memreq_type_o         = 3'd1;
                    memreq_addr_mux_sel_o = 1'b1;
                end
                ST_EVICT_WAIT:  memresp_rdy_o = 1'b1;
                ST_REFILL_REQ:  memreq_val_o  = 1'b1;
                ST_REFILL_WAIT: begin
                    memresp_rdy_o         = 1'b1;
                    memresp_data_reg_en_o = memresp_val_i;
                end
                ST_REFILL_UPDATE: begin
                    tag_array_wen_o   = 1'b1;
                    data_array_wen_o  = 1'b1;
                    data_array_wben_o = 16'hFFFF;
                end
                ST_WAIT: begin
                    cacheresp_val_o     = 1'b1;
                    cacheresp_type_o    = cachereq_type_i;
                    read_word_mux_sel_o = (is_write || is_init) ? 3'd0 : ({1'b0, off} + 3'd1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_mem_blocking_cache_base_ctrl.sv
// tb/tb_lab3_mem_blocking_cache_base_ctrl.sv - directed self-checking bench for the blocking cache control FSM
module tb_lab3_mem_blocking_cache_base_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cachereq_val_i = 1'b0, cacheresp_rdy_i = 1'b0;
    logic        memreq_rdy_i = 1'b0, memresp_val_i = 1'b0;
    logic [2:0]  cachereq_type_i = 3'd0;
    logic [31:0] cachereq_addr_i = 32'd0;
    logic        tag_match_i = 1'b0;
    logic        cachereq_rdy_o, cacheresp_val_o, memreq_val_o, memresp_rdy_o;
    logic        cachereq_en_o, tag_array_ren_o, tag_array_wen_o, data_array_ren_o, data_array_wen_o;
    logic [15:0] data_array_wben_o;
    logic        write_data_mux_sel_o, read_data_reg_en_o, hit_reg_en_o;
    logic [2:0]  read_word_mux_sel_o, cacheresp_type_o, memreq_type_o;
    logic [1:0]  tag_check_hit_o;
    logic        memreq_addr_mux_sel_o, memresp_data_reg_en_o, evict_addr_reg_en_o;

    lab3_mem_blocking_cache_base_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cachereq_val_i(cachereq_val_i), .cachereq_rdy_o(cachereq_rdy_o),
        .cacheresp_val_o(cacheresp_val_o), .cacheresp_rdy_i(cacheresp_rdy_i),
        .memreq_val_o(memreq_val_o), .memreq_rdy_i(memreq_rdy_i),
        .memresp_val_i(memresp_val_i), .memresp_rdy_o(memresp_rdy_o),
        .cachereq_type_i(cachereq_type_i), .cachereq_addr_i(cachereq_addr_i),
        .tag_match_i(tag_match_i), .cachereq_en_o(cachereq_en_o),
        .tag_array_ren_o(tag_array_ren_o), .tag_array_wen_o(tag_array_wen_o),
        .data_array_ren_o(data_array_ren_o), .data_array_wen_o(data_array_wen_o),
        .data_array_wben_o(data_array_wben_o), .write_data_mux_sel_o(write_data_mux_sel_o),
        .read_data_reg_en_o(read_data_reg_en_o), .read_word_mux_sel_o(read_word_mux_sel_o),
        .hit_reg_en_o(hit_reg_en_o), .tag_check_hit_o(tag_check_hit_o),
        .cacheresp_type_o(cacheresp_type_o), .memreq_addr_mux_sel_o(memreq_addr_mux_sel_o),
        .memreq_type_o(memreq_type_o), .memresp_data_reg_en_o(memresp_data_reg_en_o),
        .evict_addr_reg_en_o(evict_addr_reg_en_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int r_lat, r_nrd, r_nwr, r_first_mt, r_stable;
    logic [1:0]  r_tch;
    logic [2:0]  r_rsel, r_rtype;
    logic [15:0] r_wben;
    logic        r_rdy_in_wait;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issues one request from IDLE (called at a negedge) and plays the memory side.
    task automatic run_req(input logic [2:0] typ, input logic [31:0] addr, input logic tm, input int stall);
        int cyc, stall_left;
        logic [4:0] held;
        stall_left = stall;
        r_lat = -1; r_nrd = 0; r_nwr = 0; r_first_mt = -1; r_stable = 1;
        r_tch = 2'd3; r_rsel = 3'd7; r_rtype = 3'd7; r_wben = 16'h0; r_rdy_in_wait = 1'b1;
        held = '0;
        cachereq_val_i = 1'b1; cachereq_type_i = typ; cachereq_addr_i = addr; tag_match_i = tm;
        @(negedge clk);
        cachereq_val_i = 1'b0;
        cyc = 1;
        while (cyc < 300) begin
            if (hit_reg_en_o) r_tch = tag_check_hit_o;
            if (data_array_wen_o && write_data_mux_sel_o) r_wben = data_array_wben_o;
            if (cacheresp_val_o) begin
                r_lat = cyc; r_rsel = read_word_mux_sel_o; r_rtype = cacheresp_type_o;
                r_rdy_in_wait = cachereq_rdy_o;
                cacheresp_rdy_i = 1'b1;
                @(negedge clk);
                cacheresp_rdy_i = 1'b0;
                return;
            end
            if (memreq_val_o) begin
                if (stall_left != stall && stall_left >= 0 &&
                    held != {memreq_val_o, memreq_type_o, memreq_addr_mux_sel_o}) r_stable = 0;
                held = {memreq_val_o, memreq_type_o, memreq_addr_mux_sel_o};
                if (stall_left > 0) begin
                    memreq_rdy_i = 1'b0;
                    stall_left--;
                end else begin
                    memreq_rdy_i = 1'b1;
                    stall_left = -1;
                    if (r_first_mt < 0) r_first_mt = int'(memreq_type_o);
                    if (memreq_type_o == 3'd1) r_nwr++; else r_nrd++;
                end
            end else memreq_rdy_i = 1'b0;
            memresp_val_i = memresp_rdy_o;
            @(negedge clk);
            cyc++;
        end
        memreq_rdy_i = 1'b0; memresp_val_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rdy_low", cachereq_rdy_o, 0);
        rst_n = 1'b1;
        #1 chk("idle_rdy", cachereq_rdy_o, 1);
        @(negedge clk);

        run_req(3'd2, 32'h00, 1'b0, 0);
        chk("init_lat", r_lat, 3);
        chk("init_tch", r_tch, 0);
        chk("init_type", r_rtype, 2);
        chk("init_wben", r_wben, 16'h000F);
        chk("init_sel", r_rsel, 0);
        chk("init_nomem", r_nrd + r_nwr, 0);
        chk("wait_no_accept", r_rdy_in_wait, 0);

        run_req(3'd0, 32'h00, 1'b1, 0);
        chk("rdhit_lat", r_lat, 3);
        chk("rdhit_tch", r_tch, 1);
        chk("rdhit_sel", r_rsel, 1);
        chk("rdhit_type", r_rtype, 0);

        run_req(3'd0, 32'h104, 1'b0, 0);
        chk("cold_tch", r_tch, 0);
        chk("cold_nrd", r_nrd, 1);
        chk("cold_nwr", r_nwr, 0);
        chk("cold_mt", r_first_mt, 0);
        chk("cold_lat", r_lat, 6);
        chk("cold_sel", r_rsel, 2);

        run_req(3'd7, 32'h10C, 1'b1, 0);
        chk("unk_lat", r_lat, 3);
        chk("unk_sel", r_rsel, 4);
        chk("unk_type", r_rtype, 7);

        run_req(3'd2, 32'h20, 1'b0, 0);
        run_req(3'd1, 32'h20, 1'b1, 0);
        chk("wrhit_lat", r_lat, 3);
        chk("wrhit_wben", r_wben, 16'h000F);
        chk("wrhit_sel", r_rsel, 0);
        chk("wrhit_type", r_rtype, 1);
        run_req(3'd1, 32'h28, 1'b1, 0);
        chk("wr28_wben", r_wben, 16'h0F00);
        run_req(3'd0, 32'h20, 1'b1, 0);
        chk("rd20_lat", r_lat, 3);
        chk("rd20_nomem", r_nrd + r_nwr, 0);

        run_req(3'd0, 32'h120, 1'b0, 0);
        chk("evict_first_wr", r_first_mt, 1);
        chk("evict_nwr", r_nwr, 1);
        chk("evict_nrd", r_nrd, 1);
        chk("evict_lat", r_lat, 9);

        run_req(3'd0, 32'h300, 1'b0, 10);
        chk("stall_stable", r_stable, 1);
        chk("stall_nrd", r_nrd, 1);
        chk("stall_lat", r_lat, 16);

        cachereq_val_i = 1'b1; cachereq_type_i = 3'd0; cachereq_addr_i = 32'h40; tag_match_i = 1'b0;
        @(negedge clk);
        cachereq_val_i = 1'b0;
        for (int i = 0; i < 20 && !memresp_rdy_o; i++) begin
            memreq_rdy_i = memreq_val_o;
            @(negedge clk);
        end
        memreq_rdy_i = 1'b0;
        chk("in_refill_wait", memresp_rdy_o, 1);
        rst_n = 1'b0;
        #1 chk("midrst_outs", {memresp_rdy_o, cachereq_rdy_o, memreq_val_o, cacheresp_val_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("postrst_idle", cachereq_rdy_o, 1);
        @(negedge clk);
        run_req(3'd0, 32'h00, 1'b1, 0);
        chk("postrst_miss_tch", r_tch, 0);
        chk("postrst_miss_nrd", r_nrd, 1);
        run_req(3'd0, 32'h20, 1'b1, 0);
        chk("postrst_noevict", r_nwr, 0);
        chk("postrst_20_nrd", r_nrd, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
